// File: rtl/prio_pkg.sv
// Shared types for the priority encoder / sequenced decoder pair.
// Index width, entry record and the one-hot decode live here so both ends agree.
package prio_pkg;
   localparam int PRIO_W = 3;
   localparam int PRIO_N = 2**PRIO_W;

   typedef enum logic {S_IDLE, S_HOLD} state_e;

   typedef struct packed {
      logic              none;
      logic [PRIO_W-1:0] idx;
   } entry_t;

   // A none entry decodes to all-zero, regardless of idx.
   function automatic logic [PRIO_N-1:0] decode_entry(input entry_t e);
      logic [PRIO_N-1:0] oh;
      oh = '0;
      if (!e.none) oh[e.idx] = 1'b1;
      return oh;
   endfunction
endpackage

// File: rtl/priority_decoder_seq_if.sv
// Request/response bundle of the sequenced decoder.
// Handshake: a transfer happens at a rising edge where in_valid && in_ready;
// in_ready depends only on registered state, never on in_valid.
interface priority_decoder_seq_if;
   import prio_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [PRIO_W-1:0] in_idx;
   logic              in_none;
   logic              clr;
   logic [PRIO_N-1:0] out_onehot;
   logic              out_valid;
   logic [PRIO_N-1:0] seen_mask;
   logic              busy;
   state_e            dbg_state;

   modport master (
      output in_valid, in_idx, in_none, clr,
      input  in_ready, out_onehot, out_valid, seen_mask, busy, dbg_state
   );

   modport slave (
      input  in_valid, in_idx, in_none, clr,
      output in_ready, out_onehot, out_valid, seen_mask, busy, dbg_state
   );
endinterface

// File: rtl/prio_skid_buf.sv
// One-entry holding slot for an index that arrives while the active line is
// still being held; its emptiness is what the upstream sees as in_ready.
module prio_skid_buf
   import prio_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push_i,
   input  entry_t push_data_i,
   input  logic   pop_i,
   output entry_t buf_data_o,
   output logic   buf_full_o,
   output logic   in_ready_o
);
   logic   full_q, full_d;
   entry_t data_q;

   // push only happens while empty and pop only while full, so they never coincide
   always_comb begin
      full_d = full_q;
      if (push_i)     full_d = 1'b1;
      else if (pop_i) full_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         if (push_i) data_q <= push_data_i;
      end
   end

   assign buf_data_o = data_q;
   assign buf_full_o = full_q;
   assign in_ready_o = !full_q;
endmodule

// File: rtl/priority_decoder_seq.sv
// Sequenced 3-to-8 decoder: each accepted index drives its one-hot line for
// HOLD cycles, with a one-entry buffer for gap-free back-to-back output.
module priority_decoder_seq
   import prio_pkg::*;
#(
   parameter int HOLD = 4
) (
   input logic                   clk,
   input logic                   rst_n,
   priority_decoder_seq_if.slave bus
);
   localparam logic [7:0] RELOAD = 8'(HOLD - 1);

   state_e            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   entry_t            act_q, act_d;
   logic [PRIO_N-1:0] onehot_q, onehot_d;
   logic [PRIO_N-1:0] seen_q, seen_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;

   entry_t in_entry, buf_data;
   logic   accept, load, push, pop, buf_full, in_ready;

   assign in_entry = {bus.in_none, bus.in_idx};
   assign accept   = bus.in_valid && in_ready;

   prio_skid_buf u_skid (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push),
      .push_data_i (in_entry),
      .pop_i       (pop),
      .buf_data_o  (buf_data),
      .buf_full_o  (buf_full),
      .in_ready_o  (in_ready)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      act_d   = act_q;
      load    = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               act_d   = in_entry;
               load    = 1'b1;
               cnt_d   = RELOAD;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (cnt_q == 8'd0) begin
               // buffered entry has priority; it was accepted earlier
               if (buf_full) begin
                  act_d = buf_data;
                  pop   = 1'b1;
                  load  = 1'b1;
                  cnt_d = RELOAD;
               end else if (accept) begin
                  act_d = in_entry;
                  load  = 1'b1;
                  cnt_d = RELOAD;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
               push  = accept;
            end
         end
         default: state_d = S_IDLE;
      endcase

      valid_d  = (state_d == S_HOLD);
      onehot_d = load ? decode_entry(act_d) : (valid_d ? onehot_q : '0);
      // clr drops history, but a line loaded on the same edge still counts
      seen_d   = bus.clr ? (load ? onehot_d : '0) : (seen_q | onehot_d);
      busy_d   = valid_d || push || (buf_full && !pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= 8'd0;
         act_q    <= '0;
         onehot_q <= '0;
         seen_q   <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         act_q    <= act_d;
         onehot_q <= onehot_d;
         seen_q   <= seen_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_onehot = onehot_q;
   assign bus.out_valid  = valid_q;
   assign bus.seen_mask  = seen_q;
   assign bus.busy       = busy_q;
   assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_priority_decoder_seq.sv
// Directed bench for priority_decoder_seq: a HOLD=4 instance for the table and
// multi-cycle sequences, and a HOLD=1 instance for the single-cycle stream.
module tb_priority_decoder_seq;
  import prio_pkg::*;

  localparam int HOLD_A = 4;

  typedef struct {
    logic       none;
    logic [2:0] idx;
    logic [7:0] exp_onehot;
    logic [7:0] exp_seen;
  } vec_t;

  typedef logic [2:0] idx_arr_t [8];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] exp_q[$];
  vec_t vecs[5];
  idx_arr_t items;

  priority_decoder_seq_if a_if ();
  priority_decoder_seq_if b_if ();

  priority_decoder_seq #(.HOLD(HOLD_A)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if.slave)
  );

  priority_decoder_seq #(.HOLD(1)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // driver: offer one entry to instance A, return #1 after the accepting edge
  task automatic send_a(input logic none, input logic [2:0] idx, input logic clr);
    int guard;
    guard = 0;
    a_if.in_valid = 1'b1;
    a_if.in_none  = none;
    a_if.in_idx   = idx;
    a_if.clr      = clr;
    while (!a_if.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check("send_ready_timeout", a_if.in_ready, 1);
    tick();
    a_if.in_valid = 1'b0;
    a_if.clr      = 1'b0;
  endtask

  task automatic wait_idle_a();
    int g;
    g = 0;
    while (a_if.busy && g < 50) begin
      tick();
      g++;
    end
    check("idle_a_busy", a_if.busy, 0);
  endtask

  // driver + scoreboard: in_valid held high over a list of indices
  task automatic stream_a(input idx_arr_t its, input int cnt, input string tag);
    int   n;
    logic rdy;
    logic started;
    logic saw_block;
    logic done;
    n = 0;
    started = 1'b0;
    saw_block = 1'b0;
    done = 1'b0;
    exp_q.delete();
    for (int i = 0; i < cnt; i++)
      for (int h = 0; h < HOLD_A; h++)
        exp_q.push_back(8'd1 << its[i]);
    a_if.in_valid = 1'b1;
    a_if.in_none  = 1'b0;
    a_if.in_idx   = its[0];
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      rdy = a_if.in_ready;
      tick();
      if (a_if.in_valid && rdy) begin
        n++;
        if (n < cnt) a_if.in_idx = its[n];
        else a_if.in_valid = 1'b0;
      end
      if (!a_if.in_ready) saw_block = 1'b1;
      if (a_if.out_valid) started = 1'b1;
      if (started) begin
        if (exp_q.size() > 0) check({tag, "_line"}, a_if.out_onehot, exp_q.pop_front());
        else begin
          check({tag, "_end_valid"}, a_if.out_valid, 0);
          done = 1'b1;
        end
      end
    end
    a_if.in_valid = 1'b0;
    if (!done) check({tag, "_timeout"}, exp_q.size(), 0);
    check({tag, "_ready_dropped"}, saw_block, 1);
  endtask

  initial begin
    vecs[0] = '{1'b0, 3'd5, 8'h20, 8'h20};
    vecs[1] = '{1'b1, 3'd3, 8'h00, 8'h20};
    vecs[2] = '{1'b0, 3'd0, 8'h01, 8'h21};
    vecs[3] = '{1'b0, 3'd7, 8'h80, 8'hA1};
    vecs[4] = '{1'b0, 3'd3, 8'h08, 8'hA9};

    a_if.in_valid = 1'b0; a_if.in_idx = '0; a_if.in_none = 1'b0; a_if.clr = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_idx = '0; b_if.in_none = 1'b0; b_if.clr = 1'b0;

    // reset state
    #12;
    check("rst_onehot", a_if.out_onehot, 0);
    check("rst_valid", a_if.out_valid, 0);
    check("rst_seen", a_if.seen_mask, 0);
    check("rst_busy", a_if.busy, 0);
    check("rst_ready", a_if.in_ready, 1);
    check("rst_state", a_if.dbg_state, S_IDLE);
    check("rst_b_ready", b_if.in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // table: single entries, each held exactly HOLD_A cycles after 1-cycle latency
    for (int v = 0; v < 5; v++) begin
      send_a(vecs[v].none, vecs[v].idx, 1'b0);
      for (int k = 0; k < HOLD_A; k++) begin
        check("vec_valid", a_if.out_valid, 1);
        check("vec_onehot", a_if.out_onehot, vecs[v].exp_onehot);
        tick();
      end
      check("vec_after_valid", a_if.out_valid, 0);
      check("vec_after_onehot", a_if.out_onehot, 0);
      check("vec_seen", a_if.seen_mask, vecs[v].exp_seen);
    end

    // clr while idle
    a_if.clr = 1'b1;
    tick();
    a_if.clr = 1'b0;
    check("clr_idle_seen", a_if.seen_mask, 0);

    // back-to-back 1,4,7 through the skid buffer
    items = '{3'd1, 3'd4, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    stream_a(items, 3, "b2b3");
    check("b2b3_seen", a_if.seen_mask, 8'h92);
    wait_idle_a();

    // all eight lines back-to-back
    items = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    stream_a(items, 8, "b2b8");
    check("b2b8_seen", a_if.seen_mask, 8'hFF);
    wait_idle_a();

    // clr on the same edge that idx=2 loads
    send_a(1'b0, 3'd2, 1'b1);
    check("clr_load_seen", a_if.seen_mask, 8'h04);
    check("clr_load_onehot", a_if.out_onehot, 8'h04);
    wait_idle_a();

    // reset mid-hold with idx=6 active and idx=0 buffered
    send_a(1'b0, 3'd6, 1'b0);
    a_if.in_valid = 1'b1;
    a_if.in_idx   = 3'd0;
    tick();
    a_if.in_valid = 1'b0;
    check("mid_onehot", a_if.out_onehot, 8'h40);
    check("mid_ready", a_if.in_ready, 0);
    check("mid_busy", a_if.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_onehot", a_if.out_onehot, 0);
    check("arst_valid", a_if.out_valid, 0);
    check("arst_busy", a_if.busy, 0);
    check("arst_seen", a_if.seen_mask, 0);
    check("arst_ready", a_if.in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("post_rst_valid", a_if.out_valid, 0);
      check("post_rst_onehot", a_if.out_onehot, 0);
    end
    check("post_rst_busy", a_if.busy, 0);

    // HOLD=1: one line per cycle, buffer never used
    b_if.in_valid = 1'b1;
    b_if.in_idx   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("h1_onehot", b_if.out_onehot, 8'd1 << k);
      check("h1_ready", b_if.in_ready, 1);
      if (k < 7) b_if.in_idx = 3'(k + 1);
      else b_if.in_valid = 1'b0;
    end
    tick();
    check("h1_end_valid", b_if.out_valid, 0);
    check("h1_seen", b_if.seen_mask, 8'hFF);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/priority_decoder_seq.md
Name: priority_decoder_seq

Overview:
Sequenced 3-to-8 decoder, the inverse of the team's priority encoder. It accepts encoded indices over a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles. It keeps a sticky OR-mask of every line driven since the last clear, which reconstructs an 8-bit request vector. It sits on the return path from arbitration/encode logic back to per-line enables, and supports encoder-to-decoder round-trip checks.

Parameters:
W, 3, index width in bits
N, 2**W (8), number of one-hot output lines; derived, not overridden
HOLD, 4, cycles each decoded line stays asserted; legal range 1..255

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  index offered
in_ready  output  1  block can accept; transfer occurs when in_valid && in_ready at a rising edge
in_idx  input  W  encoded index to decode
in_none  input  1  encoder reported no active input (all-zero D); decodes to all-zero output
clr  input  1  synchronous clear of seen_mask
out_onehot  output  N  registered one-hot line, or zero
out_valid  output  1  out_onehot currently holding a decoded entry (including a none entry)
seen_mask  output  N  sticky OR of all out_onehot values since reset/clr
busy  output  1  out_valid || buffer occupied

Behaviour:
- Reset (rst_n low, asynchronous): out_onehot=0, out_valid=0, seen_mask=0, busy=0, in_ready=1. FSM goes to IDLE, hold counter=0, buffer empty.
- Storage: one active register (idx, none) plus one 1-entry skid buffer.
- in_ready = !buf_full. It is registered-state derived and has no combinational path from in_valid.
- FSM states: IDLE, HOLD.
  - IDLE: an accepted entry loads the active register. The next cycle, out_valid=1 and out_onehot = none ? 0 : (1 << idx). The counter loads HOLD-1. Go to HOLD. Latency from accept to output is 1 cycle.
  - HOLD: the output holds steady. The counter decrements each cycle.
  - HOLD, counter==0, buffer full: load the buffer entry into active on the same edge. Back-to-back output with no gap cycle; the counter reloads to HOLD-1.
  - HOLD, counter==0, buffer empty, accept this cycle: the accepted entry goes straight to active with no gap. Otherwise return to IDLE; out_valid=0 and out_onehot=0 the next cycle.
  - HOLD, counter!=0: an accepted entry goes to the buffer.
- HOLD=1: each entry is shown for exactly 1 cycle. A continuous stream with in_valid held high gives back-to-back outputs, one per cycle. The buffer never fills in this case.
- in_idx is unsigned W-bit. Every value 0..N-1 is legal; there is no out-of-range case.
- in_none is checked before in_idx. A none entry occupies the full HOLD period with out_valid=1 and out_onehot=0.
- seen_mask:
  - Each cycle, seen_mask <= clr ? 0 : (seen_mask | out_onehot_next).
  - If clr coincides with a new output, clr wins for the old contents. The newly loaded line is ORed in: the result is the one-hot of the new entry only.
- Reset mid-HOLD: everything returns to reset values immediately. Any buffered entry is discarded.
- busy = out_valid || buf_full, registered.

Decomposition:
- Shared package `prio_pkg` holds:
  - parameters PRIO_W=3 and PRIO_N=8;
  - FSM state enum {IDLE, HOLD};
  - typedef of the entry struct {none, idx[PRIO_W-1:0]}.
- The encoder and this block both import prio_pkg.
- One natural sub-module: `prio_skid_buf`, the 1-entry buffer that produces in_ready and buf_full. The decode/FSM stays in the top module.

Test Plan:
- Reset, then one transfer idx=5 with HOLD=4 -> out_onehot=8'b0010_0000 and out_valid=1 for exactly 4 cycles starting 1 cycle after accept. Then both outputs are 0 and seen_mask=8'h20.
- Three entries idx=1, 4, 7 with in_valid held high -> in_ready drops while the buffer is full. The outputs 8'h02, 8'h10, 8'h80 each last 4 cycles with no gap cycles. Final seen_mask=8'h92.
- Entry with in_none=1 (idx=3 ignored) -> out_valid=1 and out_onehot=0 for 4 cycles. seen_mask is unchanged.
- clr asserted on the same cycle that idx=2 loads, with prior seen_mask=8'hFF -> the next seen_mask is 8'h04.
- rst_n pulsed low mid-HOLD, with idx=6 active and idx=0 buffered -> all outputs are 0 asynchronously and in_ready=1. After release, no residual output appears.
- HOLD=1, a stream of idx 0..7 every cycle -> out_onehot walks 8'h01..8'h80 on consecutive cycles. Final seen_mask=8'hFF and in_ready stays high throughout.
